task_10_src_arbiter: RTL and testbench



---
 rtl/task_10_src_arbiter_pkg.sv | 29 ++
 rtl/task_10_src_arbiter_sat.sv | 19 +
 rtl/task_10_src_arbiter.sv | 177 +++++++++++++++++
 tb/tb_task_10_src_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/task_10_src_arbiter_pkg.sv
// Shared types for the task 10 two-source packet arbiter: FSM states, grant encoding
// and the round-robin pick used when leaving idle.
package task_10_src_arbiter_pkg;

    typedef enum logic [1:0] {
        s_IDLE = 2'd0,
        s_PASS = 2'd1,
        s_PAD  = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_S0   = 2'b01;
    localparam logic [1:0] GRANT_S1   = 2'b10;

    // last_src is the source most recently served; on a tie the other one wins.
    function automatic logic [1:0] rr_pick(input logic v0, input logic v1, input logic last_src);
        logic [1:0] g;
        g = GRANT_NONE;
        if (v0 && v1) begin
            g = last_src ? GRANT_S0 : GRANT_S1;
        end else if (v0) begin
            g = GRANT_S0;
        end else if (v1) begin
            g = GRANT_S1;
        end
        return g;
    endfunction

endpackage

// File: rtl/task_10_src_arbiter_sat.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module task_10_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         sclr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (sclr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/task_10_src_arbiter.sv
// Packet-granular round-robin arbiter feeding the task 10 input block from two byte streams.
// Zero-latency datapath; a stalled granted source is terminated with a zero pad beat.
module task_10_src_arbiter
    import task_10_src_arbiter_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_s0_tvalid,
    input  logic [DATA_W-1:0] i_s0_tdata,
    input  logic              i_s0_tlast,
    output logic              o_s0_tready,
    input  logic              i_s1_tvalid,
    input  logic [DATA_W-1:0] i_s1_tdata,
    input  logic              i_s1_tlast,
    output logic              o_s1_tready,
    output logic              o_m_tvalid,
    output logic [DATA_W-1:0] o_m_tdata,
    output logic              o_m_tlast,
    input  logic              i_m_tready,
    output logic [1:0]        o_grant,
    output logic              o_busy,
    output logic              o_timeout,
    output logic [CNT_W-1:0]  o_pkt_cnt0,
    output logic [CNT_W-1:0]  o_pkt_cnt1,
    output logic [CNT_W-1:0]  o_err_cnt
);

    localparam int                 STALL_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(TIMEOUT_CYCLES);

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic               last_src_q, last_src_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [STALL_W-1:0] stall_inc;

    logic               g_vld;
    logic [DATA_W-1:0]  g_dat;
    logic               g_last;
    logic               beat_acc;
    logic               inc0, inc1, inc_err;

    // Granted-source mux; selects nothing when no grant is held.
    always_comb begin
        g_vld  = 1'b0;
        g_dat  = '0;
        g_last = 1'b0;
        if (grant_q == GRANT_S0) begin
            g_vld  = i_s0_tvalid;
            g_dat  = i_s0_tdata;
            g_last = i_s0_tlast;
        end else if (grant_q == GRANT_S1) begin
            g_vld  = i_s1_tvalid;
            g_dat  = i_s1_tdata;
            g_last = i_s1_tlast;
        end
    end

    // Master valid is gated by ready: the input block writes on valid alone.
    always_comb begin
        o_m_tvalid  = 1'b0;
        o_m_tdata   = '0;
        o_m_tlast   = 1'b0;
        o_s0_tready = 1'b0;
        o_s1_tready = 1'b0;
        case (state_q)
            s_PASS: begin
                o_m_tvalid  = g_vld && i_m_tready;
                o_m_tdata   = g_dat;
                o_m_tlast   = g_last;
                o_s0_tready = (grant_q == GRANT_S0) && i_m_tready;
                o_s1_tready = (grant_q == GRANT_S1) && i_m_tready;
            end
            s_PAD: begin
                o_m_tvalid = i_m_tready;
                o_m_tlast  = 1'b1;
            end
            default: ;
        endcase
    end

    assign beat_acc  = o_m_tvalid;
    assign stall_inc = stall_q + STALL_W'(1);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_src_d = last_src_q;
        stall_d    = stall_q;
        inc0       = 1'b0;
        inc1       = 1'b0;
        inc_err    = 1'b0;
        case (state_q)
            s_IDLE: begin
                if (i_s0_tvalid || i_s1_tvalid) begin
                    grant_d = rr_pick(i_s0_tvalid, i_s1_tvalid, last_src_q);
                    state_d = s_PASS;
                    stall_d = '0;
                end
            end
            s_PASS: begin
                if (beat_acc) begin
                    stall_d = '0;
                    if (g_last) begin
                        inc0       = (grant_q == GRANT_S0);
                        inc1       = (grant_q == GRANT_S1);
                        last_src_d = (grant_q == GRANT_S1);
                        grant_d    = GRANT_NONE;
                        state_d    = s_IDLE;
                    end
                end else if (i_m_tready) begin
                    // Ready downstream but nothing from the granted source: a real stall.
                    stall_d = stall_inc;
                    if (stall_inc == STALL_LIM) begin
                        state_d = s_PAD;
                    end
                end
            end
            s_PAD: begin
                if (i_m_tready) begin
                    inc_err    = 1'b1;
                    last_src_d = (grant_q == GRANT_S1);
                    grant_d    = GRANT_NONE;
                    state_d    = s_IDLE;
                end
            end
            default: begin
                state_d = s_IDLE;
                grant_d = GRANT_NONE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= s_IDLE;
            grant_q    <= GRANT_NONE;
            last_src_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_src_q <= last_src_d;
            stall_q    <= stall_d;
        end
    end

    assign o_grant   = grant_q;
    assign o_busy    = (state_q != s_IDLE);
    assign o_timeout = (state_q == s_PAD) && i_m_tready;

    task_10_sat_counter #(.W(CNT_W)) u_cnt0 (
        .clk  (i_clk),
        .sclr (i_rst),
        .inc  (inc0),
        .cnt  (o_pkt_cnt0)
    );

    task_10_sat_counter #(.W(CNT_W)) u_cnt1 (
        .clk  (i_clk),
        .sclr (i_rst),
        .inc  (inc1),
        .cnt  (o_pkt_cnt1)
    );

    task_10_sat_counter #(.W(CNT_W)) u_err (
        .clk  (i_clk),
        .sclr (i_rst),
        .inc  (inc_err),
        .cnt  (o_err_cnt)
    );

endmodule

// File: tb/tb_task_10_src_arbiter.sv
// Bench for task_10_src_arbiter: per-cycle comparison against a packet-level model,
// plus directed scenarios with hand-computed beat, grant and counter expectations.
module tb_task_10_src_arbiter;
    import task_10_src_arbiter_pkg::*;

    localparam int DATA_W  = 8;
    localparam int TMO     = 8;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              s0_vld = 1'b0;
    logic [DATA_W-1:0] s0_dat = '0;
    logic              s0_last = 1'b0;
    logic              s0_rdy;
    logic              s1_vld = 1'b0;
    logic [DATA_W-1:0] s1_dat = '0;
    logic              s1_last = 1'b0;
    logic              s1_rdy;
    logic              m_vld;
    logic [DATA_W-1:0] m_dat;
    logic              m_last;
    logic              m_rdy;
    logic [1:0]        grant;
    logic              busy;
    logic              tmo;
    logic [CNT_W-1:0]  cnt0, cnt1, errc;

    always #5 clk = ~clk;

    task_10_src_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_s0_tvalid (s0_vld),
        .i_s0_tdata  (s0_dat),
        .i_s0_tlast  (s0_last),
        .o_s0_tready (s0_rdy),
        .i_s1_tvalid (s1_vld),
        .i_s1_tdata  (s1_dat),
        .i_s1_tlast  (s1_last),
        .o_s1_tready (s1_rdy),
        .o_m_tvalid  (m_vld),
        .o_m_tdata   (m_dat),
        .o_m_tlast   (m_last),
        .i_m_tready  (m_rdy),
        .o_grant     (grant),
        .o_busy      (busy),
        .o_timeout   (tmo),
        .o_pkt_cnt0  (cnt0),
        .o_pkt_cnt1  (cnt1),
        .o_err_cnt   (errc)
    );

    typedef struct {
        logic [DATA_W-1:0] dat;
        logic              last;
        int                gap;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: which source owns the output, whether it is being padded,
    // how long it has stalled, who was served last, and the three counts.
    int  m_src   = -1;
    bit  m_pad   = 1'b0;
    int  m_stall = 0;
    int  m_lastg = 1;
    int  m_c0 = 0, m_c1 = 0, m_err = 0;

    int              grant_log[$];
    logic [8:0]      acc_log[$];
    int              acc_cnt = 0;
    int              tmo_cnt = 0;
    bit              acc0 = 1'b0, acc1 = 1'b0;

    logic              e_gv, e_gl, e_mv;
    logic [DATA_W-1:0] e_gd;
    logic [1:0]        e_grant;

    always @(negedge clk) begin
        e_gv = 1'b0; e_gl = 1'b0; e_gd = '0;
        if (m_src == 0) begin
            e_gv = s0_vld; e_gd = s0_dat; e_gl = s0_last;
        end else if (m_src == 1) begin
            e_gv = s1_vld; e_gd = s1_dat; e_gl = s1_last;
        end
        e_grant = (m_src < 0) ? GRANT_NONE : ((m_src == 0) ? GRANT_S0 : GRANT_S1);
        e_mv    = (m_src >= 0) && m_rdy && (m_pad || e_gv);

        check("grant", grant, e_grant);
        check("busy", busy, m_src >= 0);
        check("m_tvalid", m_vld, e_mv);
        check("s0_tready", s0_rdy, (m_src == 0) && !m_pad && m_rdy);
        check("s1_tready", s1_rdy, (m_src == 1) && !m_pad && m_rdy);
        check("timeout", tmo, (m_src >= 0) && m_pad && m_rdy);
        check("pkt_cnt0", cnt0, m_c0);
        check("pkt_cnt1", cnt1, m_c1);
        check("err_cnt", errc, m_err);
        if (e_mv) begin
            check("m_tdata", m_dat, m_pad ? '0 : e_gd);
            check("m_tlast", m_last, m_pad ? 1'b1 : e_gl);
        end

        acc0 = s0_rdy && s0_vld;
        acc1 = s1_rdy && s1_vld;
        if (m_vld && m_rdy) begin
            acc_log.push_back({m_last, m_dat});
            acc_cnt++;
        end
        if (tmo) tmo_cnt++;

        if (rst) begin
            m_src = -1; m_pad = 1'b0; m_stall = 0; m_lastg = 1;
            m_c0 = 0; m_c1 = 0; m_err = 0;
        end else if (m_src < 0) begin
            if (s0_vld && s1_vld) m_src = (m_lastg == 0) ? 1 : 0;
            else if (s0_vld)      m_src = 0;
            else if (s1_vld)      m_src = 1;
            if (m_src >= 0) begin
                m_stall = 0;
                grant_log.push_back(m_src);
            end
        end else if (m_pad) begin
            if (m_rdy) begin
                if (m_err < CNT_MAX) m_err++;
                m_lastg = m_src; m_src = -1; m_pad = 1'b0;
            end
        end else if (e_gv && m_rdy) begin
            m_stall = 0;
            if (e_gl) begin
                if (m_src == 0 && m_c0 < CNT_MAX) m_c0++;
                if (m_src == 1 && m_c1 < CNT_MAX) m_c1++;
                m_lastg = m_src; m_src = -1;
            end
        end else if (m_rdy) begin
            m_stall++;
            if (m_stall == TMO) m_pad = 1'b1;
        end
    end

    // Source drivers: a beat stays presented until accepted; gap = idle cycles before it.
    beat_t tmp;
    always @(posedge clk) begin
        #1;
        if (acc0 && q0.size() > 0) tmp = q0.pop_front();
        if (q0.size() == 0) begin
            s0_vld = 1'b0;
        end else if (q0[0].gap > 0) begin
            s0_vld = 1'b0;
            q0[0].gap = q0[0].gap - 1;
        end else begin
            s0_vld = 1'b1; s0_dat = q0[0].dat; s0_last = q0[0].last;
        end
        if (acc1 && q1.size() > 0) tmp = q1.pop_front();
        if (q1.size() == 0) begin
            s1_vld = 1'b0;
        end else if (q1[0].gap > 0) begin
            s1_vld = 1'b0;
            q1[0].gap = q1[0].gap - 1;
        end else begin
            s1_vld = 1'b1; s1_dat = q1[0].dat; s1_last = q1[0].last;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input int src, input logic [DATA_W-1:0] d, input logic l, input int gap);
        beat_t b;
        b.dat = d; b.last = l; b.gap = gap;
        if (src == 0) q0.push_back(b);
        else          q1.push_back(b);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && m_src < 0 && !s0_vld && !s1_vld) return;
            tick(1);
        end
        checks++; errors++;
        $display("FAIL %s: idle not reached within 300 cycles", name);
    endtask

    task automatic wait_acc(input string name, input int n);
        int target;
        target = acc_cnt + n;
        for (int i = 0; i < 300; i++) begin
            if (acc_cnt >= target) return;
            tick(1);
        end
        checks++; errors++;
        $display("FAIL %s: %0d beats not accepted within 300 cycles", name, n);
    endtask

    int a0, g0, t0;

    initial begin
        rst = 1'b1;
        m_rdy = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset grant", grant, 2'b00);
        check("reset busy", busy, 1'b0);
        check("reset cnt0", cnt0, 0);
        check("reset err", errc, 0);

        // 1: single 4-beat packet from source 0
        a0 = acc_log.size(); g0 = grant_log.size();
        push(0, 8'h11, 1'b0, 0); push(0, 8'h22, 1'b0, 0);
        push(0, 8'h33, 1'b0, 0); push(0, 8'h44, 1'b1, 0);
        wait_idle("single");
        check("single beats", acc_log.size() - a0, 4);
        check("single beat0", acc_log[a0 + 0], {1'b0, 8'h11});
        check("single beat1", acc_log[a0 + 1], {1'b0, 8'h22});
        check("single beat2", acc_log[a0 + 2], {1'b0, 8'h33});
        check("single beat3", acc_log[a0 + 3], {1'b1, 8'h44});
        check("single grant", grant_log[g0], 0);
        check("single cnt0", cnt0, 1);

        // 2: contention; source 0 was served last, so source 1 goes first
        a0 = acc_log.size(); g0 = grant_log.size();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                push(0, 8'hA0 + 8'(k * 3 + i), i == 2, 0);
                push(1, 8'hB0 + 8'(k * 3 + i), i == 2, 0);
            end
        end
        wait_idle("contention");
        check("contention grants", grant_log.size() - g0, 6);
        for (int p = 0; p < 6; p++) begin
            check("contention grant order", grant_log[g0 + p], (p % 2 == 0) ? 1 : 0);
            for (int i = 0; i < 3; i++) begin
                check("contention beat", acc_log[a0 + p * 3 + i],
                      {i == 2, ((p % 2 == 0) ? 8'hB0 : 8'hA0) + 8'((p / 2) * 3 + i)});
            end
        end
        check("contention cnt0", cnt0, 4);
        check("contention cnt1", cnt1, 3);

        // 3: backpressure while the source also has a gap; stall must not advance
        a0 = acc_log.size(); t0 = tmo_cnt;
        push(0, 8'hC1, 1'b0, 0); push(0, 8'hC2, 1'b0, 0);
        push(0, 8'hC3, 1'b0, 12); push(0, 8'hC4, 1'b0, 0); push(0, 8'hC5, 1'b1, 0);
        wait_acc("bp", 2);
        tick(4);
        m_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("bp m_tvalid", m_vld, 1'b0);
            check("bp s0_tready", s0_rdy, 1'b0);
        end
        m_rdy = 1'b1;
        wait_idle("bp");
        check("bp beats", acc_log.size() - a0, 5);
        check("bp last beat", acc_log[a0 + 4], {1'b1, 8'hC5});
        check("bp no timeout", tmo_cnt - t0, 0);
        check("bp cnt0", cnt0, 5);

        // 5: beat arrives on the cycle the stall count would hit the limit
        t0 = tmo_cnt;
        push(0, 8'hD1, 1'b0, 0); push(0, 8'hD2, 1'b1, TMO - 1);
        wait_idle("race");
        check("race no timeout", tmo_cnt - t0, 0);
        check("race err", errc, 0);
        check("race cnt0", cnt0, 6);

        // 4: source 1 stalls after two beats -> pad beat after TMO stall cycles
        a0 = acc_log.size(); t0 = tmo_cnt;
        push(1, 8'hE1, 1'b0, 0); push(1, 8'hE2, 1'b0, 0);
        wait_idle("timeout");
        check("timeout beats", acc_log.size() - a0, 3);
        check("timeout pad", acc_log[a0 + 2], {1'b1, 8'h00});
        check("timeout pulses", tmo_cnt - t0, 1);
        check("timeout err", errc, 1);
        check("timeout cnt1", cnt1, 3);

        // 6: reset mid-packet, then a tie goes to source 0
        push(0, 8'hF1, 1'b0, 0); push(0, 8'hF2, 1'b0, 0); push(0, 8'hF3, 1'b0, 0);
        push(0, 8'hF4, 1'b0, 0); push(0, 8'hF5, 1'b1, 0);
        wait_acc("rst", 2);
        rst = 1'b1;
        q0.delete();
        tick(1);
        check("rst grant", grant, 2'b00);
        check("rst busy", busy, 1'b0);
        check("rst cnt0", cnt0, 0);
        check("rst cnt1", cnt1, 0);
        check("rst err", errc, 0);
        rst = 1'b0;
        tick(1);
        g0 = grant_log.size();
        push(0, 8'h51, 1'b1, 0); push(1, 8'h61, 1'b1, 0);
        wait_idle("post rst");
        check("post rst grants", grant_log.size() - g0, 2);
        check("post rst first", grant_log[g0], 0);
        check("post rst second", grant_log[g0 + 1], 1);
        check("post rst cnt0", cnt0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
